// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake game controllers.
package snake_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    UP    = 2'd1,
    LEFT  = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Small per-channel move queue; a pop and a push may share one cycle even when full.
module move_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] tail
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr];
  assign tail    = mem[wr_ptr - 1'b1];

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // On a full queue the write slot equals the head slot; head is read before it is overwritten.
  always_ff @(posedge mclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// Per-player direction controller: sync, optional debounce (SNAKE_MOVE_DEBOUNCE_EN),
// priority pick, turn filtering and a move queue popped on each game tick.
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int PLAYERS      = 1,
  parameter int DEPTH        = 4,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic                   mclk,
  input  logic                   reset,
  input  logic [4*PLAYERS-1:0]   btn,
  input  logic                   game_tick,
  input  logic                   clear,
  output logic [2*PLAYERS-1:0]   move,
  output logic [PLAYERS-1:0]     move_valid,
  output logic [PLAYERS-1:0]     q_empty,
  output logic [PLAYERS-1:0]     overflow
);

  localparam int NB = 4 * PLAYERS;

  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] btn_edge;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef SNAKE_MOVE_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] cnt [NB];

  // Counter saturates at DEBOUNCE_CYC so a held button fires exactly once.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (clear || !sync2[i])    cnt[i] <= '0;
        else if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    btn_edge = '0;
    for (int unsigned i = 0; i < NB; i++)
      btn_edge[i] = sync2[i] && (cnt[i] == CNT_LAST) && !clear;
  end
`else
  logic [NB-1:0] sync_prev;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) sync_prev <= '0;
    else        sync_prev <= sync2;
  end

  assign btn_edge = sync2 & ~sync_prev;
`endif

  for (genvar p = 0; p < PLAYERS; p++) begin : g_ch
    logic [3:0] e;
    logic       req_v;
    dir_t       req_d;
    dir_t       ref_d;
    dir_t       move_r;
    logic       valid_r;
    logic       ovf_r;
    logic       accept;
    logic       pop;
    logic       push;
    logic       f_full;
    logic       f_empty;
    logic [1:0] f_head;
    logic [1:0] f_tail;

    assign e = btn_edge[4*p +: 4];

    always_comb begin
      req_v = |e;
      req_d = RIGHT;
      if      (e[3]) req_d = DOWN;
      else if (e[2]) req_d = LEFT;
      else if (e[1]) req_d = UP;
    end

    // With one entry left head == tail, so the tail stays the correct reference across a pop.
    assign ref_d  = f_empty ? move_r : dir_t'(f_tail);
    assign accept = req_v && (req_d != ref_d) && (req_d != reverse_dir(ref_d));
    assign pop    = game_tick && !f_empty && !clear;
    assign push   = accept && (!f_full || pop) && !clear;

    move_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2)
    ) u_fifo (
      .mclk  (mclk),
      .reset (reset),
      .flush (clear),
      .push  (push),
      .pop   (pop),
      .din   (req_d),
      .full  (f_full),
      .empty (f_empty),
      .head  (f_head),
      .tail  (f_tail)
    );

    always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
        move_r  <= RIGHT;
        valid_r <= 1'b0;
        ovf_r   <= 1'b0;
      end else if (clear) begin
        move_r  <= RIGHT;
        valid_r <= 1'b0;
        ovf_r   <= 1'b0;
      end else begin
        if (pop) move_r <= dir_t'(f_head);
        valid_r <= pop;
        if (accept && f_full && !pop) ovf_r <= 1'b1;
      end
    end

    assign move[2*p +: 2] = move_r;
    assign move_valid[p]  = valid_r;
    assign q_empty[p]     = f_empty;
    assign overflow[p]    = ovf_r;
  end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Scoreboard bench for snake_move_ctrl (PLAYERS=2, DEPTH=4, DEBOUNCE_CYC=4).
module tb_snake_move_ctrl;

  localparam int PL = 2;
  localparam int DP = 4;
  localparam int DC = 4;
`ifdef SNAKE_MOVE_DEBOUNCE_EN
  localparam bit DB_ON     = 1'b1;
  localparam int PUSH_WAIT = 5;
`else
  localparam bit DB_ON     = 1'b0;
  localparam int PUSH_WAIT = 2;
`endif

  logic            mclk = 1'b0;
  logic            reset;
  logic [4*PL-1:0] btn;
  logic            game_tick;
  logic            clear;
  logic [2*PL-1:0] move;
  logic [PL-1:0]   move_valid;
  logic [PL-1:0]   q_empty;
  logic [PL-1:0]   overflow;

  int tests = 0;
  int fails = 0;

  logic [1:0] sb [PL][$];
  logic [1:0] mmove [PL];
  logic       movf [PL];

  snake_move_ctrl #(
    .PLAYERS      (PL),
    .DEPTH        (DP),
    .DEBOUNCE_CYC (DC)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .btn        (btn),
    .game_tick  (game_tick),
    .clear      (clear),
    .move       (move),
    .move_valid (move_valid),
    .q_empty    (q_empty),
    .overflow   (overflow)
  );

  always #5 mclk = ~mclk;

  task automatic cyc();
    @(posedge mclk);
    #1;
  endtask

  function automatic void model_clear();
    for (int c = 0; c < PL; c++) begin
      sb[c].delete();
      mmove[c] = 2'd0;
      movf[c]  = 1'b0;
    end
  endfunction

  function automatic void model_req(input int ch, input logic [3:0] bits);
    logic [1:0] d;
    logic [1:0] r;
    if (bits == 4'b0) return;
    d = bits[3] ? 2'd3 : bits[2] ? 2'd2 : bits[1] ? 2'd1 : 2'd0;
    r = (sb[ch].size() > 0) ? sb[ch][$] : mmove[ch];
    if (d == r || d == (r ^ 2'b10)) return;
    if (sb[ch].size() == DP) movf[ch] = 1'b1;
    else sb[ch].push_back(d);
  endfunction

  task automatic check_status(input int ch);
    tests++;
    if (q_empty[ch] !== (sb[ch].size() == 0)) begin
      fails++;
      $display("FAIL q_empty[%0d]: got %0b expected %0b", ch, q_empty[ch], sb[ch].size() == 0);
    end
    tests++;
    if (overflow[ch] !== movf[ch]) begin
      fails++;
      $display("FAIL overflow[%0d]: got %0b expected %0b", ch, overflow[ch], movf[ch]);
    end
  endtask

  task automatic check_pop_result();
    logic exp_v;
    for (int c = 0; c < PL; c++) begin
      exp_v = (sb[c].size() > 0);
      if (exp_v) mmove[c] = sb[c].pop_front();
      tests++;
      if (move_valid[c] !== exp_v) begin
        fails++;
        $display("FAIL move_valid[%0d] on tick: got %0b expected %0b", c, move_valid[c], exp_v);
      end
      tests++;
      if (move[2*c +: 2] !== mmove[c]) begin
        fails++;
        $display("FAIL move[%0d] on tick: got %0d expected %0d", c, move[2*c +: 2], mmove[c]);
      end
    end
  endtask

  task automatic press(input int ch, input logic [3:0] bits, input int hold);
    btn[4*ch +: 4] = bits;
    repeat (hold) cyc();
    btn[4*ch +: 4] = 4'b0;
    repeat (8) cyc();
    if (DB_ON ? (hold >= DC) : (hold >= 1)) model_req(ch, bits);
    check_status(ch);
  endtask

  task automatic tick();
    game_tick = 1'b1;
    cyc();
    game_tick = 1'b0;
    check_pop_result();
    cyc();
    for (int c = 0; c < PL; c++) begin
      tests++;
      if (move_valid[c] !== 1'b0) begin
        fails++;
        $display("FAIL move_valid[%0d] pulse width: got %0b expected 0", c, move_valid[c]);
      end
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    model_clear();
    tests++;
    if (move !== '0 || move_valid !== '0 || q_empty !== '1 || overflow !== '0) begin
      fails++;
      $display("FAIL clear: got move=%0h valid=%0b empty=%0b ovf=%0b expected 0/0/11/0",
               move, move_valid, q_empty, overflow);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; btn = '0; game_tick = 1'b0; clear = 1'b0;
    model_clear();
    repeat (3) cyc();
    tests++; if (move !== '0) begin fails++; $display("FAIL reset move: got %0h expected 0", move); end
    tests++; if (move_valid !== '0) begin fails++; $display("FAIL reset move_valid: got %0b expected 0", move_valid); end
    tests++; if (q_empty !== '1) begin fails++; $display("FAIL reset q_empty: got %0b expected 11", q_empty); end
    tests++; if (overflow !== '0) begin fails++; $display("FAIL reset overflow: got %0b expected 0", overflow); end
    @(negedge mclk);
    reset = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic test_debounce();
    press(0, 4'b0010, 3);
    tick();
    press(0, 4'b0010, 6);
    tick();
    do_clear();
  endtask

  task automatic test_reject();
    press(0, 4'b0100, 6);
    press(0, 4'b1000, 6);
    tick();
    tick();
    do_clear();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) press(0, (i % 2 == 0) ? 4'b0010 : 4'b0001, 6);
    for (int i = 0; i < 5; i++) tick();
    check_status(0);
    do_clear();
  endtask

  task automatic test_full_tick();
    for (int i = 0; i < 4; i++) press(0, (i % 2 == 0) ? 4'b0010 : 4'b0001, 6);
    btn[3:0] = 4'b0010;
    repeat (PUSH_WAIT) cyc();
    game_tick = 1'b1;
    cyc();
    game_tick = 1'b0;
    check_pop_result();
    model_req(0, 4'b0010);
    repeat (6 - PUSH_WAIT - 1) cyc();
    btn[3:0] = 4'b0;
    repeat (8) cyc();
    check_status(0);
    for (int i = 0; i < 4; i++) tick();
    do_clear();
  endtask

  task automatic test_channels();
    press(1, 4'b1010, 6);
    check_status(0);
    tick();
    do_clear();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) press(0, (i % 2 == 0) ? 4'b0010 : 4'b0001, 6);
    tick();
    @(posedge mclk);
    #3;
    reset = 1'b0;
    #1;
    tests++;
    if (move !== '0 || move_valid !== '0 || q_empty !== '1 || overflow !== '0) begin
      fails++;
      $display("FAIL async reset: got move=%0h valid=%0b empty=%0b ovf=%0b expected 0/0/11/0",
               move, move_valid, q_empty, overflow);
    end
    model_clear();
    @(negedge mclk);
    reset = 1'b1;
    repeat (2) cyc();
    press(0, 4'b1000, 6);
    tick();
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_reject();
    test_overflow();
    test_full_tick();
    test_channels();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
